// File: rtl/counter_pkg.sv
// Shared constants and helpers for the timekeeping digit counters.
// Instantiating modules use min_width() to size COUNT/D from a modulus.
package counter_pkg;

    // Standard clock digit moduli
    localparam int unsigned SEC_UNITS = 10;
    localparam int unsigned SEC_TENS  = 6;
    localparam int unsigned HOUR_12   = 12;
    localparam int unsigned HOUR_24   = 24;

    // Operation selected for the coming clock edge, in priority order
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_LOAD   = 3'd2,
        OP_REJECT = 3'd3,
        OP_COUNT  = 3'd4
    } count_op_e;

    // Smallest width whose range 0..2^w-1 covers MODULUS states (at least 1)
    function automatic int unsigned min_width(input int unsigned modulus);
        int unsigned w;
        w = 31;
        for (int i = 31; i >= 1; i--) begin
            if ((64'd1 << i) >= 64'(modulus)) begin
                w = i;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-value and terminal detect for a modulo-N digit.
// Works in WIDTH+1 bits so MODULUS == 2^WIDTH compares without overflow.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 3,
    parameter int WRAP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next_val,
    output logic             at_limit
);

    localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_EXT = '0;
    localparam logic           WRAP_EN  = (WRAP != 0);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] next_ext;

    assign count_ext = {1'b0, count};

    // Terminal value depends on direction: top of range going up, zero going down
    always_comb begin
        at_limit = 1'b0;
        if (up) begin
            at_limit = (count_ext == LAST_EXT);
        end else begin
            at_limit = (count_ext == ZERO_EXT);
        end
    end

    // Step one position, wrapping or saturating at the terminal value
    always_comb begin
        next_ext = count_ext;
        if (at_limit) begin
            if (WRAP_EN) begin
                next_ext = up ? ZERO_EXT : LAST_EXT;
            end else begin
                next_ext = count_ext;
            end
        end else if (up) begin
            next_ext = count_ext + 1'b1;
        end else begin
            next_ext = count_ext - 1'b1;
        end
    end

    assign next_val = next_ext[WIDTH-1:0];

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down digit counter for the alarm-clock timekeeping chain.
// Holds the count register, clear/load/count priority and the load error pulse;
// the step arithmetic lives in counter_next_val.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int MODULUS   = 6,
    parameter int WIDTH     = 3,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Sync_Clr,
    input  logic             Enable,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             Cnt,
    input  logic             Up,
    output logic [WIDTH-1:0] COUNT,
    output logic             Carry_out,
    output logic             At_limit,
    output logic             Load_err
);

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("counter_mod_n: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
    end

    if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
        $error("counter_mod_n: RESET_VAL %0d not below MODULUS %0d", RESET_VAL, MODULUS);
    end

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT     = (WIDTH+1)'(MODULUS);
    localparam logic             WRAP_EN     = (WRAP != 0);

    logic [WIDTH-1:0] step_val;
    logic             at_limit_int;
    logic             load_ok;
    count_op_e        op;

    counter_next_val #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH),
        .WRAP    (WRAP)
    ) u_next_val (
        .count    (COUNT),
        .up       (Up),
        .next_val (step_val),
        .at_limit (at_limit_int)
    );

    // Extend D by one bit so a load of 2^WIDTH-1 checks correctly when MODULUS == 2^WIDTH
    assign load_ok = ({1'b0, D} < MOD_EXT);

    // Resolve the edge's operation: clear beats load beats count; Enable gates load and count only
    always_comb begin
        op = OP_HOLD;
        if (Sync_Clr) begin
            op = OP_CLEAR;
        end else if (LD && Enable) begin
            op = load_ok ? OP_LOAD : OP_REJECT;
        end else if (Cnt && Enable) begin
            op = OP_COUNT;
        end
    end

    // Count register and one-cycle load error pulse
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            COUNT    <= RESET_COUNT;
            Load_err <= 1'b0;
        end else begin
            Load_err <= 1'b0;
            case (op)
                OP_CLEAR:  COUNT <= RESET_COUNT;
                OP_LOAD:   COUNT <= D;
                OP_REJECT: Load_err <= 1'b1;
                OP_COUNT:  COUNT <= step_val;
                default:   COUNT <= COUNT;
            endcase
        end
    end

    assign At_limit = at_limit_int;

    // Carry fires on the same edge that wraps this digit, so the next digit steps in lockstep
    assign Carry_out = WRAP_EN & Enable & Cnt & ~LD & ~Sync_Clr & Clr & at_limit_int;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: mod-6 wrap, mod-10 saturate, mod-8 full-range
// and a mod-10 -> mod-6 cascade.
module tb_counter_mod_n;

    logic Clk;
    logic Clr;

    // mod-6, wrap
    logic       a_sync_clr, a_enable, a_ld, a_cnt, a_up;
    logic [2:0] a_d;
    logic [2:0] a_count;
    logic       a_carry, a_at_limit, a_load_err;

    // mod-10, saturate
    logic       b_sync_clr, b_enable, b_ld, b_cnt, b_up;
    logic [3:0] b_d;
    logic [3:0] b_count;
    logic       b_carry, b_at_limit, b_load_err;

    // mod-8 in 3 bits, wrap
    logic       e_sync_clr, e_enable, e_ld, e_cnt, e_up;
    logic [2:0] e_d;
    logic [2:0] e_count;
    logic       e_carry, e_at_limit, e_load_err;

    // cascade: units mod-10 feeding tens mod-6
    logic       u_enable, u_cnt;
    logic [3:0] u_count;
    logic       u_carry, u_at_limit, u_load_err;
    logic [2:0] t_count;
    logic       t_carry, t_at_limit, t_load_err;

    int checks = 0;
    int errors = 0;

    counter_mod_n #(.MODULUS(6), .WIDTH(3), .WRAP(1), .RESET_VAL(0)) dut_a (
        .Clk(Clk), .Clr(Clr), .Sync_Clr(a_sync_clr), .Enable(a_enable), .LD(a_ld),
        .D(a_d), .Cnt(a_cnt), .Up(a_up), .COUNT(a_count), .Carry_out(a_carry),
        .At_limit(a_at_limit), .Load_err(a_load_err)
    );

    counter_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP(0), .RESET_VAL(0)) dut_b (
        .Clk(Clk), .Clr(Clr), .Sync_Clr(b_sync_clr), .Enable(b_enable), .LD(b_ld),
        .D(b_d), .Cnt(b_cnt), .Up(b_up), .COUNT(b_count), .Carry_out(b_carry),
        .At_limit(b_at_limit), .Load_err(b_load_err)
    );

    counter_mod_n #(.MODULUS(8), .WIDTH(3), .WRAP(1), .RESET_VAL(0)) dut_e (
        .Clk(Clk), .Clr(Clr), .Sync_Clr(e_sync_clr), .Enable(e_enable), .LD(e_ld),
        .D(e_d), .Cnt(e_cnt), .Up(e_up), .COUNT(e_count), .Carry_out(e_carry),
        .At_limit(e_at_limit), .Load_err(e_load_err)
    );

    counter_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP(1), .RESET_VAL(0)) dut_units (
        .Clk(Clk), .Clr(Clr), .Sync_Clr(1'b0), .Enable(u_enable), .LD(1'b0),
        .D(4'd0), .Cnt(u_cnt), .Up(1'b1), .COUNT(u_count), .Carry_out(u_carry),
        .At_limit(u_at_limit), .Load_err(u_load_err)
    );

    counter_mod_n #(.MODULUS(6), .WIDTH(3), .WRAP(1), .RESET_VAL(0)) dut_tens (
        .Clk(Clk), .Clr(Clr), .Sync_Clr(1'b0), .Enable(u_enable), .LD(1'b0),
        .D(3'd0), .Cnt(u_carry), .Up(1'b1), .COUNT(t_count), .Carry_out(t_carry),
        .At_limit(t_at_limit), .Load_err(t_load_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int exp_up[7];
        int exp_dn[3];
        int um;
        int tm;

        exp_up = '{1, 2, 3, 4, 5, 0, 1};
        exp_dn = '{5, 4, 3};

        Clr = 1'b0;
        {a_sync_clr, a_enable, a_ld, a_cnt, a_up} = '0; a_d = '0;
        {b_sync_clr, b_enable, b_ld, b_cnt, b_up} = '0; b_d = '0;
        {e_sync_clr, e_enable, e_ld, e_cnt, e_up} = '0; e_d = '0;
        u_enable = 1'b0; u_cnt = 1'b0;
        #2;
        check("reset_count_a", 32'(a_count), 0);
        check("reset_load_err_a", 32'(a_load_err), 0);
        check("reset_count_b", 32'(b_count), 0);

        // mod-6 up, async clear mid-cycle, then wrap through 5 -> 0
        Clr = 1'b1;
        a_enable = 1'b1; a_cnt = 1'b1; a_up = 1'b1;
        step();
        step();
        check("pre_clr_count", 32'(a_count), 2);
        #2;
        Clr = 1'b0;
        #1;
        check("async_clr_count", 32'(a_count), 0);
        Clr = 1'b1;
        #1;
        check("carry_at_0_up", 32'(a_carry), 0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("up_count", 32'(a_count), 32'(exp_up[i]));
            check("up_carry", 32'(a_carry), (exp_up[i] == 5) ? 1 : 0);
        end

        // sync clear, then count down from 0
        a_cnt = 1'b0; a_sync_clr = 1'b1;
        step();
        check("sync_clr_count", 32'(a_count), 0);
        a_sync_clr = 1'b0; a_up = 1'b0; a_cnt = 1'b1;
        #1;
        check("down_carry_at_0", 32'(a_carry), 1);
        check("down_at_limit_0", 32'(a_at_limit), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("down_count", 32'(a_count), 32'(exp_dn[i]));
            check("down_carry", 32'(a_carry), 0);
        end
        a_cnt = 1'b0;

        // load range checking
        a_ld = 1'b1; a_d = 3'd7;
        step();
        check("rej7_count", 32'(a_count), 3);
        check("rej7_err", 32'(a_load_err), 1);
        a_ld = 1'b0;
        step();
        check("err_one_cycle", 32'(a_load_err), 0);
        check("after_rej_count", 32'(a_count), 3);
        a_ld = 1'b1; a_d = 3'd6;
        step();
        check("rej6_count", 32'(a_count), 3);
        check("rej6_err", 32'(a_load_err), 1);
        a_d = 3'd4;
        step();
        check("load4_count", 32'(a_count), 4);
        check("load4_err", 32'(a_load_err), 0);

        // priority
        a_sync_clr = 1'b1; a_ld = 1'b1; a_d = 3'd2; a_cnt = 1'b1; a_up = 1'b1;
        step();
        check("prio_clr_count", 32'(a_count), 0);
        a_sync_clr = 1'b0;
        step();
        check("prio_ld_over_cnt", 32'(a_count), 2);
        a_enable = 1'b0; a_d = 3'd5;
        step();
        check("disabled_hold", 32'(a_count), 2);
        a_ld = 1'b0; a_cnt = 1'b0; a_sync_clr = 1'b1;
        step();
        check("sync_clr_no_enable", 32'(a_count), 0);
        a_sync_clr = 1'b0; a_enable = 1'b1; a_ld = 1'b1; a_d = 3'd5;
        step();
        check("load5_count", 32'(a_count), 5);
        a_d = 3'd1; a_cnt = 1'b1;
        #1;
        check("ld_at_limit", 32'(a_at_limit), 1);
        check("ld_blocks_carry", 32'(a_carry), 0);
        a_ld = 1'b0;
        #1;
        check("carry_unblocked", 32'(a_carry), 1);
        a_enable = 1'b0;
        #1;
        check("enable_blocks_carry", 32'(a_carry), 0);
        a_enable = 1'b1; a_sync_clr = 1'b1;
        #1;
        check("sclr_blocks_carry", 32'(a_carry), 0);
        step();
        check("sclr_final", 32'(a_count), 0);
        {a_sync_clr, a_ld, a_cnt} = '0;

        // mod-10 saturating
        b_enable = 1'b1; b_ld = 1'b1; b_d = 4'd9;
        step();
        check("b_load9", 32'(b_count), 9);
        b_ld = 1'b0; b_cnt = 1'b1; b_up = 1'b1;
        #1;
        check("b_at_limit_9", 32'(b_at_limit), 1);
        check("b_no_carry", 32'(b_carry), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_sat_up", 32'(b_count), 9);
        end
        check("b_at_limit_after", 32'(b_at_limit), 1);
        b_up = 1'b0;
        #1;
        check("b_at_limit_down9", 32'(b_at_limit), 0);
        step();
        check("b_down_8", 32'(b_count), 8);
        step();
        check("b_down_7", 32'(b_count), 7);
        b_cnt = 1'b0; b_ld = 1'b1; b_d = 4'd10;
        step();
        check("b_rej10_count", 32'(b_count), 7);
        check("b_rej10_err", 32'(b_load_err), 1);
        b_d = 4'd0;
        step();
        check("b_load0", 32'(b_count), 0);
        b_ld = 1'b0; b_cnt = 1'b1;
        #1;
        check("b_no_carry_0", 32'(b_carry), 0);
        step();
        check("b_sat_down", 32'(b_count), 0);
        b_cnt = 1'b0;

        // mod-8 filling all 3 bits
        e_enable = 1'b1; e_ld = 1'b1; e_d = 3'd7;
        step();
        check("e_load7", 32'(e_count), 7);
        check("e_load7_err", 32'(e_load_err), 0);
        e_ld = 1'b0; e_cnt = 1'b1; e_up = 1'b1;
        #1;
        check("e_carry_up", 32'(e_carry), 1);
        step();
        check("e_wrap_up", 32'(e_count), 0);
        e_up = 1'b0;
        #1;
        check("e_carry_down", 32'(e_carry), 1);
        step();
        check("e_wrap_down", 32'(e_count), 7);
        e_cnt = 1'b0;

        // cascade units -> tens
        um = 0;
        tm = 0;
        u_enable = 1'b1; u_cnt = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            check("casc_u_carry", 32'(u_carry), (um == 9) ? 1 : 0);
            check("casc_t_carry", 32'(t_carry), ((um == 9) && (tm == 5)) ? 1 : 0);
            step();
            if (um == 9) begin
                um = 0;
                tm = (tm == 5) ? 0 : tm + 1;
            end else begin
                um = um + 1;
            end
            check("casc_units", 32'(u_count), 32'(um));
            check("casc_tens", 32'(t_count), 32'(tm));
        end
        check("casc_units_end", 32'(u_count), 0);
        check("casc_tens_end", 32'(t_count), 0);
        u_cnt = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
